muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the execute stage, beside the ALU and branch unit. It consumes the forwarded execute-stage operands and funct3 of an M-extension instruction. It computes MUL/MULH/MULHSU/MULHU in 2 cycles and DIV/DIVU/REM/REMU by 32-step restoring division. It holds the execute stage via a stall output until the result is ready for the writeback mux.

---
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_unit.sv | 126 ++++++++++++
 tb/tb_muldiv_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the M-extension unit.
// The pipeline drives operands and start; the unit answers with stall/done/result.
interface muldiv_if;
   logic        startE;
   logic        flushE;
   logic [2:0]  funct3E;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        stallE;
   logic        doneE;
   logic [31:0] resultE;

   modport master (
      output startE, flushE, funct3E, SrcAE, SrcBE,
      input  stallE, doneE, resultE
   );

   modport slave (
      input  startE, flushE, funct3E, SrcAE, SrcBE,
      output stallE, doneE, resultE
   );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: 2-cycle multiply, 32-step restoring divide.
// Holds the execute stage through stallE until the registered result is ready.
module muldiv_unit (
   input  logic     clk,
   input  logic     clr_n,
   muldiv_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t      state, nxt;
   logic [31:0] a_q, b_q, rem_q, res_q;
   logic [1:0]  f3_q;
   logic [4:0]  cnt_q;
   logic        sq_q, sr_q;

   logic        accept, sgn, div_zero, div_ovf, special;
   logic [31:0] abs_a, abs_b, spec_res;
   logic        mas, mbs;
   logic [63:0] ax, bx, prod;
   logic [32:0] r_sh, diff;
   logic [31:0] rem_n, quo_n, q_fin, r_fin;

   assign accept   = (state == S_IDLE) & bus.startE & ~bus.flushE;
   assign sgn      = ~bus.funct3E[0];
   assign abs_a    = (sgn & bus.SrcAE[31]) ? -bus.SrcAE : bus.SrcAE;
   assign abs_b    = (sgn & bus.SrcBE[31]) ? -bus.SrcBE : bus.SrcBE;
   assign div_zero = (bus.SrcBE == 32'd0);
   assign div_ovf  = sgn & (bus.SrcAE == 32'h8000_0000)
                         & (bus.SrcBE == 32'hFFFF_FFFF);
   assign special  = div_zero | div_ovf;

   always_comb begin
      spec_res = 32'd0;
      unique case (1'b1)
         div_zero: spec_res = bus.funct3E[1] ? bus.SrcAE : 32'hFFFF_FFFF;
         div_ovf:  spec_res = bus.funct3E[1] ? 32'd0 : 32'h8000_0000;
         default:  spec_res = 32'd0;
      endcase
   end

   // 01 MULH: both signed; 10 MULHSU: only rs1 signed
   assign mas  = ((f3_q == 2'b01) | (f3_q == 2'b10)) & a_q[31];
   assign mbs  = (f3_q == 2'b01) & b_q[31];
   assign ax   = {{32{mas}}, a_q};
   assign bx   = {{32{mbs}}, b_q};
   assign prod = ax * bx;

   // a_q doubles as the dividend/quotient shift register during DIV
   assign r_sh  = {rem_q, a_q[31]};
   assign diff  = r_sh - {1'b0, b_q};
   assign rem_n = diff[32] ? r_sh[31:0] : diff[31:0];
   assign quo_n = {a_q[30:0], ~diff[32]};
   assign q_fin = sq_q ? -quo_n : quo_n;
   assign r_fin = sr_q ? -rem_n : rem_n;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (!bus.funct3E[2]) nxt = S_MUL;
               else if (special)    nxt = S_DONE;
               else                 nxt = S_DIV;
            end
         end
         S_MUL:  nxt = bus.flushE ? S_IDLE : S_DONE;
         S_DIV: begin
            if (bus.flushE)        nxt = S_IDLE;
            else if (&cnt_q)       nxt = S_DONE;
         end
         S_DONE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         rem_q <= 32'd0;
         res_q <= 32'd0;
         f3_q  <= 2'd0;
         cnt_q <= 5'd0;
         sq_q  <= 1'b0;
         sr_q  <= 1'b0;
      end else if (accept) begin
         f3_q  <= bus.funct3E[1:0];
         cnt_q <= 5'd0;
         rem_q <= 32'd0;
         sq_q  <= sgn & (bus.SrcAE[31] ^ bus.SrcBE[31]);
         sr_q  <= sgn & bus.SrcAE[31];
         if (!bus.funct3E[2]) begin
            a_q <= bus.SrcAE;
            b_q <= bus.SrcBE;
         end else begin
            a_q <= abs_a;
            b_q <= abs_b;
            if (special) res_q <= spec_res;
         end
      end else if (state == S_MUL && !bus.flushE) begin
         res_q <= (f3_q == 2'b00) ? prod[31:0] : prod[63:32];
      end else if (state == S_DIV && !bus.flushE) begin
         rem_q <= rem_n;
         a_q   <= quo_n;
         cnt_q <= cnt_q + 5'd1;
         if (&cnt_q) res_q <= f3_q[1] ? r_fin : q_fin;
      end
   end

   assign bus.stallE  = clr_n & (accept | (state == S_MUL)
                                        | (state == S_DIV));
   assign bus.doneE   = (state == S_DONE);
   assign bus.resultE = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: products, quotients, special cases,
// flush and mid-operation reset, with hand-computed expectations.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   muldiv_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue at cycle N (inputs set after a falling edge), hold startE until done
   task automatic run_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      int   n;
      logic st_ok;
      @(negedge clk);
      bus.startE  = 1'b1;
      bus.funct3E = f;
      bus.SrcAE   = a;
      bus.SrcBE   = b;
      #1;
      chk({tag, "_stallN"}, 32'(bus.stallE), 32'd1);
      n = 0;
      st_ok = 1'b1;
      for (int k = 1; k <= 40 && n == 0; k++) begin
         @(negedge clk);
         #1;
         if (bus.doneE) n = k;
         else if (!bus.stallE) st_ok = 1'b0;
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_res"}, bus.resultE, exp);
      chk({tag, "_stall_busy"}, 32'(st_ok), 32'd1);
      chk({tag, "_stall_done"}, 32'(bus.stallE), 32'd0);
      @(negedge clk);
      bus.startE = 1'b0;
      #1;
      chk({tag, "_after"}, {30'd0, bus.doneE, bus.stallE}, 32'd0);
   endtask

   initial begin
      bus.startE  = 1'b0;
      bus.flushE  = 1'b0;
      bus.funct3E = 3'd0;
      bus.SrcAE   = 32'd0;
      bus.SrcBE   = 32'd0;
      #1;
      chk("rst_stall", 32'(bus.stallE), 32'd0);
      chk("rst_done", 32'(bus.doneE), 32'd0);
      chk("rst_res", bus.resultE, 32'd0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;

      run_op("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
      run_op("mulh",   3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2);
      run_op("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 2);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 2);
      run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 2);

      // Flush a DIV at N+10; result must keep 0x40000000
      @(negedge clk);
      bus.startE  = 1'b1;
      bus.funct3E = 3'b100;
      bus.SrcAE   = 32'd100;
      bus.SrcBE   = 32'd7;
      repeat (10) @(negedge clk);
      bus.flushE = 1'b1;
      bus.startE = 1'b0;
      @(negedge clk);
      bus.flushE = 1'b0;
      #1;
      chk("flush_done", 32'(bus.doneE), 32'd0);
      chk("flush_stall", 32'(bus.stallE), 32'd0);
      chk("flush_res", bus.resultE, 32'h4000_0000);
      run_op("mul_postflush", 3'b000, 32'd6, 32'd7, 32'd42, 2);

      run_op("div",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("divu",  3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
      run_op("remu",  3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33);
      run_op("div0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
      run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 1);
      run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

      // Reset at N+5 of a DIV
      @(negedge clk);
      bus.startE  = 1'b1;
      bus.funct3E = 3'b100;
      bus.SrcAE   = 32'd50;
      bus.SrcBE   = 32'd5;
      repeat (5) @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk("rstmid_stall", 32'(bus.stallE), 32'd0);
      chk("rstmid_done", 32'(bus.doneE), 32'd0);
      chk("rstmid_res", bus.resultE, 32'd0);
      bus.startE = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      run_op("divu_postrst", 3'b101, 32'd9, 32'd3, 32'd3, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
